// File: rtl/filter2d_out_packer.sv
// Packs the filter2d 8-bit pixel stream into 32-bit words, tags the word holding
// a frame's final pixel, and queues words in a show-ahead FIFO for a valid/ready consumer.
module filter2d_out_packer #(
   parameter int IMG_W      = 256,
   parameter int IMG_H      = 256,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        n_reset,
   input  logic        i_strb,
   input  logic [7:0]  i_data,
   output logic        o_valid,
   input  logic        o_ready,
   output logic [31:0] o_data,
   output logic        o_last,
   output logic        o_ovf,
   output logic [15:0] o_frame_cnt
);

   localparam int NPIX   = IMG_W * IMG_H;
   localparam int PCNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int CW     = AW + 1;
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(NPIX - 1);
   localparam logic [CW-1:0]     OCC_FULL  = CW'(FIFO_DEPTH);

   logic [1:0]        bidx_r;
   logic [23:0]       hold_r;
   logic [PCNT_W-1:0] pcnt_r;
   logic [15:0]       frame_cnt_r;
   logic              ovf_r;
   logic [32:0]       mem_r [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_r;
   logic [AW-1:0]     rd_ptr_r;
   logic [CW-1:0]     occ_r;
   logic              out_valid_r;
   logic [32:0]       out_word_r;

   logic              pix_last_s;
   logic              word_done_s;
   logic [31:0]       word_s;
   logic [32:0]       entry_s;
   logic              full_s;
   logic              pop_s;
   logic              push_s;
   logic              drop_s;
   logic [CW-1:0]     occ_next_s;
   logic [CW-1:0]     occ_after_pop_s;
   logic [AW-1:0]     rd_ptr_next_s;
   logic [32:0]       head_next_s;

   // Word assembly: held bytes below bidx, the incoming pixel at bidx, zeros above.
   always_comb begin
      pix_last_s  = 1'b0;
      word_done_s = 1'b0;
      word_s      = 32'h0000_0000;
      if (pcnt_r == PCNT_LAST) begin
         pix_last_s = 1'b1;
      end else begin
         pix_last_s = 1'b0;
      end
      if (i_strb && ((bidx_r == 2'd3) || pix_last_s)) begin
         word_done_s = 1'b1;
      end else begin
         word_done_s = 1'b0;
      end
      case (bidx_r)
         2'd0:    word_s = {24'h00_0000, i_data};
         2'd1:    word_s = {16'h0000, i_data, hold_r[7:0]};
         2'd2:    word_s = {8'h00, i_data, hold_r[15:0]};
         2'd3:    word_s = {i_data, hold_r};
         default: word_s = 32'h0000_0000;
      endcase
      entry_s = {pix_last_s, word_s};
   end

   // FIFO control; a push into a full FIFO survives only when a pop frees a slot on the same edge.
   always_comb begin
      full_s          = (occ_r == OCC_FULL);
      pop_s           = out_valid_r && o_ready;
      push_s          = word_done_s && (!full_s || pop_s);
      drop_s          = word_done_s && full_s && !pop_s;
      occ_after_pop_s = occ_r - CW'(pop_s);
      occ_next_s      = occ_after_pop_s + CW'(push_s);
      rd_ptr_next_s   = rd_ptr_r + AW'(pop_s);
      // Bypass the memory when the incoming word becomes the head this edge.
      if (occ_after_pop_s == {CW{1'b0}}) begin
         head_next_s = entry_s;
      end else begin
         head_next_s = mem_r[rd_ptr_next_s];
      end
   end

   // Pack state: byte index, holding bytes, raster position and frame counter.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         bidx_r      <= 2'd0;
         hold_r      <= 24'h00_0000;
         pcnt_r      <= {PCNT_W{1'b0}};
         frame_cnt_r <= 16'h0000;
      end else if (i_strb) begin
         if (word_done_s) begin
            bidx_r <= 2'd0;
         end else begin
            bidx_r <= bidx_r + 2'd1;
         end
         case (bidx_r)
            2'd0:    hold_r[7:0]   <= i_data;
            2'd1:    hold_r[15:8]  <= i_data;
            2'd2:    hold_r[23:16] <= i_data;
            default: hold_r        <= hold_r;
         endcase
         if (pix_last_s) begin
            pcnt_r      <= {PCNT_W{1'b0}};
            frame_cnt_r <= frame_cnt_r + 16'd1;
         end else begin
            pcnt_r <= pcnt_r + PCNT_W'(1'b1);
         end
      end else begin
         bidx_r <= bidx_r;
      end
   end

   // Word storage carries no reset; occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= entry_s;
      end
   end

   // Pointers, occupancy, sticky overflow and the registered head word.
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         wr_ptr_r    <= {AW{1'b0}};
         rd_ptr_r    <= {AW{1'b0}};
         occ_r       <= {CW{1'b0}};
         ovf_r       <= 1'b0;
         out_valid_r <= 1'b0;
         out_word_r  <= 33'h0_0000_0000;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1'b1);
         end else begin
            wr_ptr_r <= wr_ptr_r;
         end
         rd_ptr_r <= rd_ptr_next_s;
         occ_r    <= occ_next_s;
         if (drop_s) begin
            ovf_r <= 1'b1;
         end else begin
            ovf_r <= ovf_r;
         end
         out_valid_r <= (occ_next_s != {CW{1'b0}});
         if (occ_next_s != {CW{1'b0}}) begin
            out_word_r <= head_next_s;
         end else begin
            out_word_r <= out_word_r;
         end
      end
   end

   assign o_valid     = out_valid_r;
   assign o_data      = out_word_r[31:0];
   assign o_last      = out_word_r[32];
   assign o_ovf       = ovf_r;
   assign o_frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_filter2d_out_packer.sv
// Bench for filter2d_out_packer: directed vector table, hand-written FIFO corner
// sequences and a randomized run against a queue-based reference model.
module tb_filter2d_out_packer;

   localparam int A_W = 4, A_H = 3, A_D = 8;
   localparam int B_W = 5, B_H = 1, B_D = 2;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        strb = 1'b0;
   logic [7:0]  din = 8'h00;
   logic        rdy = 1'b0;
   logic [1:0]  vld, lst, ovf;
   logic [31:0] dat0, dat1;
   logic [15:0] fcnt0, fcnt1;

   int vecs = 0;
   int fails = 0;

   always #5 clk = ~clk;

   filter2d_out_packer #(.IMG_W(A_W), .IMG_H(A_H), .FIFO_DEPTH(A_D)) u_a (
      .clk(clk), .n_reset(n_reset), .i_strb(strb), .i_data(din),
      .o_valid(vld[0]), .o_ready(rdy), .o_data(dat0), .o_last(lst[0]),
      .o_ovf(ovf[0]), .o_frame_cnt(fcnt0));

   filter2d_out_packer #(.IMG_W(B_W), .IMG_H(B_H), .FIFO_DEPTH(B_D)) u_b (
      .clk(clk), .n_reset(n_reset), .i_strb(strb), .i_data(din),
      .o_valid(vld[1]), .o_ready(rdy), .o_data(dat1), .o_last(lst[1]),
      .o_ovf(ovf[1]), .o_frame_cnt(fcnt1));

   typedef struct {
      bit          rst;
      int          sel;
      logic        strb;
      logic [7:0]  data;
      logic        rdy;
      logic        ev;
      logic [31:0] ed;
      logic        el;
      logic [15:0] ef;
   } vec_t;

   vec_t tbl[$];

   // ---------------- reference model ----------------
   int          m_pix[2];
   int          m_nb[2];
   logic [31:0] m_acc[2];
   int          m_frm[2];
   bit          m_ovf[2];
   logic [32:0] q0[$];
   logic [32:0] q1[$];

   function automatic int npix(int d);
      return (d == 0) ? A_W * A_H : B_W * B_H;
   endfunction
   function automatic int depth(int d);
      return (d == 0) ? A_D : B_D;
   endfunction
   function automatic int qsize(int d);
      return (d == 0) ? q0.size() : q1.size();
   endfunction
   function automatic logic [32:0] qfront(int d);
      return (d == 0) ? q0[0] : q1[0];
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_pix[d] = 0; m_nb[d] = 0; m_acc[d] = 32'h0; m_frm[d] = 0; m_ovf[d] = 1'b0;
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic model_edge(int d, logic s, logic [7:0] x, logic r);
      int          sz;
      bit          pop;
      bit          lastp;
      bit          wd;
      logic [32:0] w;
      sz  = qsize(d);
      pop = r && (sz > 0);
      wd  = 1'b0;
      w   = 33'h0;
      if (s) begin
         m_acc[d] = m_acc[d] | (32'(x) << (8 * m_nb[d]));
         lastp    = (m_pix[d] == npix(d) - 1);
         if (m_nb[d] == 3 || lastp) begin
            wd = 1'b1; w = {lastp, m_acc[d]}; m_acc[d] = 32'h0; m_nb[d] = 0;
         end else begin
            m_nb[d]++;
         end
         if (lastp) begin m_pix[d] = 0; m_frm[d]++; end
         else m_pix[d]++;
      end
      if (pop) begin
         if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
      if (wd) begin
         if (sz - int'(pop) < depth(d)) begin
            if (d == 0) q0.push_back(w); else q1.push_back(w);
         end else begin
            m_ovf[d] = 1'b1;
         end
      end
   endtask

   // ---------------- helpers ----------------
   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      vecs++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      strb = 1'b0; rdy = 1'b0;
      n_reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_reset = 1'b1;
      model_reset();
   endtask

   function automatic logic [31:0] wrd(int k);
      return {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
   endfunction

   function automatic vec_t mkrow(bit rst, int sel, logic s, logic [7:0] x, logic r,
                                  logic ev, logic [31:0] ed, logic el, logic [15:0] ef);
      vec_t v;
      v.rst = rst; v.sel = sel; v.strb = s; v.data = x; v.rdy = r;
      v.ev = ev; v.ed = ed; v.el = el; v.ef = ef;
      return v;
   endfunction

   task automatic check_model(int d, string tag);
      logic [32:0] f;
      chk({tag, "_valid"}, 64'(vld[d]), 64'(qsize(d) > 0));
      if (qsize(d) > 0) begin
         f = qfront(d);
         chk({tag, "_data"}, 64'((d == 0) ? dat0 : dat1), 64'(f[31:0]));
         chk({tag, "_last"}, 64'(lst[d]), 64'(f[32]));
      end
      chk({tag, "_ovf"}, 64'(ovf[d]), 64'(m_ovf[d]));
      chk({tag, "_fcnt"}, 64'((d == 0) ? fcnt0 : fcnt1), 64'(16'(m_frm[d])));
   endtask

   initial begin
      // ---------- vector table ----------
      for (int i = 1; i <= 12; i++) begin
         tbl.push_back(mkrow(i == 1, 0, 1'b1, 8'(i), 1'b1, (i % 4) == 0,
                             {8'(i), 8'(i-1), 8'(i-2), 8'(i-3)}, i == 12, 16'(i == 12)));
      end
      tbl.push_back(mkrow(0, 0, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0, 16'd1));
      tbl.push_back(mkrow(1, 1, 1'b1, 8'hA1, 1'b1, 1'b0, 32'h0, 1'b0, 16'd0));
      tbl.push_back(mkrow(0, 1, 1'b1, 8'hA2, 1'b1, 1'b0, 32'h0, 1'b0, 16'd0));
      tbl.push_back(mkrow(0, 1, 1'b1, 8'hA3, 1'b1, 1'b0, 32'h0, 1'b0, 16'd0));
      tbl.push_back(mkrow(0, 1, 1'b1, 8'hA4, 1'b1, 1'b1, 32'hA4A3A2A1, 1'b0, 16'd0));
      tbl.push_back(mkrow(0, 1, 1'b1, 8'hA5, 1'b1, 1'b1, 32'h000000A5, 1'b1, 16'd1));
      tbl.push_back(mkrow(0, 1, 1'b0, 8'h00, 1'b1, 1'b0, 32'h0, 1'b0, 16'd1));

      // reset state
      #3;
      chk("rst_valid", 64'(vld), 64'(2'b00));
      chk("rst_data", 64'(dat0), 64'(32'h0));
      chk("rst_last", 64'(lst), 64'(2'b00));
      chk("rst_ovf", 64'(ovf), 64'(2'b00));
      chk("rst_fcnt", 64'(fcnt0), 64'(16'h0));
      @(negedge clk);
      n_reset = 1'b1;

      foreach (tbl[i]) begin
         if (tbl[i].rst) do_reset();
         strb = tbl[i].strb; din = tbl[i].data; rdy = tbl[i].rdy;
         cyc();
         chk("tbl_valid", 64'(vld[tbl[i].sel]), 64'(tbl[i].ev));
         if (tbl[i].ev) begin
            chk("tbl_data", 64'((tbl[i].sel == 0) ? dat0 : dat1), 64'(tbl[i].ed));
            chk("tbl_last", 64'(lst[tbl[i].sel]), 64'(tbl[i].el));
         end
         chk("tbl_fcnt", 64'((tbl[i].sel == 0) ? fcnt0 : fcnt1), 64'(tbl[i].ef));
      end
      strb = 1'b0;

      // ---------- overflow: 9 words into an 8-deep FIFO with no consumer ----------
      do_reset();
      for (int n = 0; n < 36; n++) begin
         strb = 1'b1; din = 8'(n + 1); cyc();
      end
      strb = 1'b0;
      chk("ovf_set", 64'(ovf[0]), 64'(1'b1));
      chk("ovf_fcnt", 64'(fcnt0), 64'(16'd3));
      rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         chk("ovf_pop_valid", 64'(vld[0]), 64'(1'b1));
         chk("ovf_pop_data", 64'(dat0), 64'(wrd(k)));
         chk("ovf_pop_last", 64'(lst[0]), 64'((k % 3) == 2));
         cyc();
      end
      chk("ovf_drained", 64'(vld[0]), 64'(1'b0));
      chk("ovf_sticky", 64'(ovf[0]), 64'(1'b1));

      // ---------- full FIFO with a pop on the edge the ninth word completes ----------
      do_reset();
      for (int n = 0; n < 36; n++) begin
         strb = 1'b1; din = 8'(n + 1); rdy = (n == 35);
         cyc();
      end
      strb = 1'b0; rdy = 1'b0;
      chk("full_pop_ovf", 64'(ovf[0]), 64'(1'b0));
      cyc();
      chk("full_pop_hold", 64'(dat0), 64'(wrd(1)));
      rdy = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         chk("full_pop_valid", 64'(vld[0]), 64'(1'b1));
         chk("full_pop_data", 64'(dat0), 64'(wrd(k)));
         cyc();
      end
      chk("full_pop_empty", 64'(vld[0]), 64'(1'b0));
      chk("full_pop_ovf_end", 64'(ovf[0]), 64'(1'b0));

      // ---------- reset in the middle of a frame ----------
      do_reset();
      rdy = 1'b0;
      for (int n = 0; n < 6; n++) begin
         strb = 1'b1; din = 8'h50 + 8'(n); cyc();
      end
      strb = 1'b0;
      chk("mid_pre_valid", 64'(vld[0]), 64'(1'b1));
      #2 n_reset = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(vld[0]), 64'(1'b0));
      chk("mid_rst_data", 64'(dat0), 64'(32'h0));
      chk("mid_rst_last", 64'(lst[0]), 64'(1'b0));
      chk("mid_rst_fcnt", 64'(fcnt0), 64'(16'h0));
      @(negedge clk);
      n_reset = 1'b1;
      model_reset();
      rdy = 1'b1;
      for (int n = 0; n < 12; n++) begin
         strb = 1'b1; din = 8'h10 + 8'(n); cyc();
         if ((n % 4) == 3) begin
            chk("mid_word_valid", 64'(vld[0]), 64'(1'b1));
            chk("mid_word_data", 64'(dat0),
                64'({8'h10 + 8'(n), 8'h0F + 8'(n), 8'h0E + 8'(n), 8'h0D + 8'(n)}));
            chk("mid_word_last", 64'(lst[0]), 64'(n == 11));
         end
      end
      strb = 1'b0;
      chk("mid_fcnt", 64'(fcnt0), 64'(16'd1));

      // ---------- randomized run against the reference model ----------
      do_reset();
      for (int c = 0; c < 5200; c++) begin
         check_model(0, "rnd_a");
         check_model(1, "rnd_b");
         if (c == 2400) begin
            do_reset();
            check_model(0, "rnd_a_rst");
            check_model(1, "rnd_b_rst");
         end
         if (c < 900) begin
            strb = ((c % 17) == 0);
            rdy  = ($urandom_range(0, 1) == 1) || (c % 2 == 0);
         end else if (c < 3800) begin
            strb = ($urandom_range(0, 1) == 1);
            rdy  = ($urandom_range(0, 3) != 0);
         end else begin
            strb = 1'b1;
            rdy  = ($urandom_range(0, 3) == 0);
         end
         din = 8'($urandom_range(0, 255));
         model_edge(0, strb, din, rdy);
         model_edge(1, strb, din, rdy);
         cyc();
      end
      check_model(0, "rnd_a_end");
      check_model(1, "rnd_b_end");

      $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
      $finish;
   end

endmodule
